// File: rtl/sdes_pkg.sv
// rtl/sdes_pkg.sv - shared widths, FSM states and key-ordering helper for S-DES key search
package sdes_pkg;

    localparam int KEY_W    = 10;
    localparam int BLK_W    = 8;
    localparam int KEYSPACE = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Switch order (SW[0] first) to key-schedule order (bit 1 of the schedule is the MSB)
    function automatic logic [KEY_W-1:0] bit_rev(input logic [KEY_W-1:0] v);
        logic [KEY_W-1:0] r;
        for (int i = 0; i < KEY_W; i++) begin
            r[i] = v[KEY_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/Encrypt.sv
// rtl/Encrypt.sv - S-DES two-round encryption of one byte under subkeys k1/k2
module Encrypt (
    input  logic [7:0] plaintext,
    input  logic [7:0] k1,
    input  logic [7:0] k2,
    output logic [7:0] ciphertext
);

    function automatic logic [1:0] sbox0(input logic [3:0] rc);
        case (rc)
            4'd0:  return 2'd1;  4'd1:  return 2'd0;  4'd2:  return 2'd3;  4'd3:  return 2'd2;
            4'd4:  return 2'd3;  4'd5:  return 2'd2;  4'd6:  return 2'd1;  4'd7:  return 2'd0;
            4'd8:  return 2'd0;  4'd9:  return 2'd2;  4'd10: return 2'd1;  4'd11: return 2'd3;
            4'd12: return 2'd3;  4'd13: return 2'd1;  4'd14: return 2'd3;  default: return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] sbox1(input logic [3:0] rc);
        case (rc)
            4'd0:  return 2'd0;  4'd1:  return 2'd1;  4'd2:  return 2'd2;  4'd3:  return 2'd3;
            4'd4:  return 2'd2;  4'd5:  return 2'd0;  4'd6:  return 2'd1;  4'd7:  return 2'd3;
            4'd8:  return 2'd3;  4'd9:  return 2'd0;  4'd10: return 2'd1;  4'd11: return 2'd0;
            4'd12: return 2'd2;  4'd13: return 2'd1;  4'd14: return 2'd0;  default: return 2'd3;
        endcase
    endfunction

    // Round function: expand, mix subkey, S-boxes (row = outer bits), P4
    function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] sk);
        logic [7:0] x;
        logic [3:0] s;
        x = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ sk;
        s = {sbox0({x[7], x[4], x[6], x[5]}), sbox1({x[3], x[0], x[2], x[1]})};
        return {s[2], s[0], s[1], s[3]};
    endfunction

    logic [7:0] ip;
    logic [3:0] l1;
    logic [3:0] l2;
    logic [7:0] pre;

    // IP, round 1 with k1, halves swapped, round 2 with k2, inverse IP
    always_comb begin
        ip  = {plaintext[6], plaintext[2], plaintext[5], plaintext[7],
               plaintext[4], plaintext[0], plaintext[3], plaintext[1]};
        l1  = ip[7:4] ^ f_round(ip[3:0], k1);
        l2  = ip[3:0] ^ f_round(l1, k2);
        pre = {l2, l1};
        ciphertext = {pre[4], pre[7], pre[5], pre[3], pre[1], pre[6], pre[0], pre[2]};
    end

endmodule

// File: rtl/key_gen.sv
// rtl/key_gen.sv - S-DES key schedule: 10-bit key to subkeys k1 and k2
module key_gen (
    input  logic [9:0] key10,
    output logic [7:0] k1,
    output logic [7:0] k2
);

    logic [9:0] p10;
    logic [9:0] ls1;
    logic [9:0] ls2;

    // P8 only uses schedule positions 3..10, so it takes the low eight bits
    function automatic logic [7:0] p8(input logic [7:0] x);
        return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
    endfunction

    // P10, then circular shifts of each five-bit half by one and by a further two
    always_comb begin
        p10 = {key10[7], key10[5], key10[8], key10[3], key10[6],
               key10[0], key10[9], key10[1], key10[2], key10[4]};
        ls1 = {p10[8:5], p10[9], p10[3:0], p10[4]};
        ls2 = {ls1[7:5], ls1[9:8], ls1[2:0], ls1[4:3]};
        k1  = p8(ls1[7:0]);
        k2  = p8(ls2[7:0]);
    end

endmodule

// File: rtl/sdes_cipher_comb.sv
// rtl/sdes_cipher_comb.sv - combinational S-DES encrypt from a switch-order key
module sdes_cipher_comb
    import sdes_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [BLK_W-1:0] block,
    output logic [BLK_W-1:0] cipher
);

    logic [KEY_W-1:0] key_sched;
    logic [7:0]       k1;
    logic [7:0]       k2;

    assign key_sched = bit_rev(key);

    key_gen u_key_gen (
        .key10 (key_sched),
        .k1    (k1),
        .k2    (k2)
    );

    Encrypt u_encrypt (
        .plaintext  (block),
        .k1         (k1),
        .k2         (k2),
        .ciphertext (cipher)
    );

endmodule

// File: rtl/sdes_key_search.sv
// rtl/sdes_key_search.sv - exhaustive known-plaintext S-DES key search, one key per clock
module sdes_key_search
    import sdes_pkg::*;
#(
    parameter bit STOP_ON_FIRST = 1'b0
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [BLK_W-1:0]  plaintext,
    input  logic [BLK_W-1:0]  ciphertext,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [KEY_W-1:0]  key_out,
    output logic [KEY_W:0]    match_count
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_cand;
    logic             hit;
    logic [KEY_W-1:0] cand;
    logic [BLK_W-1:0] pt_q;
    logic [BLK_W-1:0] ct_q;
    logic [BLK_W-1:0] trial;

    sdes_cipher_comb u_cipher (
        .key    (cand),
        .block  (pt_q),
        .cipher (trial)
    );

    assign hit       = (trial == ct_q);
    assign last_cand = (cand == KEY_W'(KEYSPACE - 1));
    assign busy      = (state == ST_SEARCH);
    assign done      = (state == ST_DONE);

    // State register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; start is honoured in IDLE and DONE so searches can run back to back
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SEARCH;
                    accept     = 1'b1;
                end
            end
            ST_SEARCH: begin
                if (last_cand || (STOP_ON_FIRST && hit)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_SEARCH;
                    accept     = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Latched pair, candidate counter and results; results hold until the next accepted start
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pt_q        <= '0;
            ct_q        <= '0;
            cand        <= '0;
            found       <= 1'b0;
            key_out     <= '0;
            match_count <= '0;
        end else if (accept) begin
            pt_q        <= plaintext;
            ct_q        <= ciphertext;
            cand        <= '0;
            found       <= 1'b0;
            key_out     <= '0;
            match_count <= '0;
        end else if (state == ST_SEARCH) begin
            if (hit) begin
                match_count <= match_count + 1'b1;
                if (!found) begin
                    found   <= 1'b1;
                    key_out <= cand;
                end
            end
            if (!last_cand) begin
                cand <= cand + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdes_key_search.sv
// tb/tb_sdes_key_search.sv - self-checking bench for sdes_key_search
module tb_sdes_key_search;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic        start0   = 1'b0;
    logic        start1   = 1'b0;
    logic [7:0]  plaintext  = 8'h00;
    logic [7:0]  ciphertext = 8'h00;
    logic        busy0, done0, found0, busy1, done1, found1;
    logic [9:0]  key0, key1;
    logic [10:0] count0, count1;

    int checks   = 0;
    int failures = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    sdes_key_search #(.STOP_ON_FIRST(1'b0)) dut_full (
        .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N), .start (start0),
        .plaintext (plaintext), .ciphertext (ciphertext),
        .busy (busy0), .done (done0), .found (found0),
        .key_out (key0), .match_count (count0)
    );

    sdes_key_search #(.STOP_ON_FIRST(1'b1)) dut_stop (
        .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N), .start (start1),
        .plaintext (plaintext), .ciphertext (ciphertext),
        .busy (busy1), .done (done1), .found (found1),
        .key_out (key1), .match_count (count1)
    );

    // ---------------- reference model: S-DES from its textbook tables ----------------
    localparam int P10_T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_T[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    localparam int IP_T[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    localparam int IPI_T[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    localparam int EP_T[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    localparam int P4_T[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    localparam int S0[16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
    localparam int S1[16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

    // Output position j takes input position t[j] (1 = MSB)
    function automatic int permute(input int v, input int nin, input int nout, input int t[10]);
        int r = 0;
        for (int j = 0; j < nout; j++) r = (r << 1) | ((v >> (nin - t[j])) & 1);
        return r;
    endfunction

    function automatic int rotl5(input int x, input int n);
        return ((x << n) | (x >> (5 - n))) & 31;
    endfunction

    function automatic int model_f(input int r, input int sk);
        int x, a, b, s;
        x = permute(r, 4, 8, EP_T) ^ sk;
        a = x >> 4;
        b = x & 15;
        s = S0[(((a >> 3) & 1) * 2 + (a & 1)) * 4 + ((a >> 1) & 3)] * 4
          + S1[(((b >> 3) & 1) * 2 + (b & 1)) * 4 + ((b >> 1) & 3)];
        return permute(s, 4, 4, P4_T);
    endfunction

    function automatic int model_enc(input int sw_key, input int pt);
        int k = 0, p, l, r, k1, k2, ip, hl, hr, t;
        for (int i = 0; i < 10; i++) k |= ((sw_key >> i) & 1) << (9 - i);
        p  = permute(k, 10, 10, P10_T);
        l  = rotl5(p >> 5, 1);
        r  = rotl5(p & 31, 1);
        k1 = permute((l << 5) | r, 10, 8, P8_T);
        l  = rotl5(l, 2);
        r  = rotl5(r, 2);
        k2 = permute((l << 5) | r, 10, 8, P8_T);
        ip = permute(pt, 8, 8, IP_T);
        hl = (ip >> 4) ^ model_f(ip & 15, k1);
        hr = ip & 15;
        t = hl; hl = hr; hr = t;
        hl = hl ^ model_f(hr, k2);
        return permute((hl << 4) | hr, 8, 8, IPI_T);
    endfunction

    typedef struct {
        bit          stop;
        logic [7:0]  pt;
        logic [7:0]  ct;
        bit          exp_found;
        logic [9:0]  exp_key;
        logic [10:0] exp_count;
        int          exp_cycles;
    } vec_t;

    function automatic vec_t model_search(input bit stop, input int pt, input int ct);
        vec_t v;
        int cnt = 0, low = -1;
        for (int k = 0; k < 1024; k++) begin
            if (model_enc(k, pt) == ct) begin
                cnt++;
                if (low < 0) low = k;
            end
        end
        v.stop      = stop;
        v.pt        = 8'(pt);
        v.ct        = 8'(ct);
        v.exp_found = (cnt > 0);
        v.exp_key   = (low < 0) ? 10'd0 : 10'(low);
        if (stop) v.exp_count = (cnt > 0) ? 11'd1 : 11'd0;
        else      v.exp_count = 11'(cnt);
        v.exp_cycles = (stop && low >= 0) ? low + 2 : 1025;
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"},  int'(busy0) + int'(busy1), 0);
        chk({name, "_done"},  int'(done0) + int'(done1), 0);
        chk({name, "_found"}, int'(found0) + int'(found1), 0);
        chk({name, "_key"},   int'(key0) + int'(key1), 0);
        chk({name, "_count"}, int'(count0) + int'(count1), 0);
    endtask

    // Drive start for one rising edge (edge 0); returns just after that edge
    task automatic launch(input bit which, input logic [7:0] pt, input logic [7:0] ct);
        @(negedge CLOCK_50);
        plaintext  = pt;
        ciphertext = ct;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Called just after edge 0; cycles = n+1 where edge n is the one that raised done
    task automatic wait_done(input bit which, input int poke_at, input int rst_at,
                             output int cycles, output bit aborted);
        int n = 0;
        cycles  = -1;
        aborted = 1'b0;
        while (n < 1200) begin
            @(negedge CLOCK_50);
            if (poke_at >= 0 && n == poke_at) begin
                start0 = 1'b1; plaintext = 8'h12; ciphertext = 8'h34;
            end
            if (poke_at >= 0 && n == poke_at + 1) begin
                start0 = 1'b0; plaintext = 8'h55; ciphertext = 8'hAA;
            end
            if (rst_at >= 0 && n == rst_at) begin
                RESET_N = 1'b0;
                #1;
                chk_all_zero("midsearch_reset");
                aborted = 1'b1;
                break;
            end
            if (which ? done1 : done0) begin
                cycles = n + 1;
                break;
            end
            @(posedge CLOCK_50);
            n++;
        end
        if (!aborted && cycles < 0) chk("wait_done_timeout", 1, 0);
    endtask

    task automatic check_result(input string name, input vec_t v, input int cycles);
        chk({name, "_cycles"}, cycles, v.exp_cycles);
        chk({name, "_busy"},  int'(v.stop ? busy1 : busy0), 0);
        chk({name, "_found"}, int'(v.stop ? found1 : found0), int'(v.exp_found));
        chk({name, "_key"},   int'(v.stop ? key1 : key0), int'(v.exp_key));
        chk({name, "_count"}, int'(v.stop ? count1 : count0), int'(v.exp_count));
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int  cycles;
        bit  ab;
        launch(v.stop, v.pt, v.ct);
        wait_done(v.stop, -1, -1, cycles, ab);
        check_result(name, v, cycles);
        @(posedge CLOCK_50);
        #1;
        chk({name, "_done_pulse"}, int'(v.stop ? done1 : done0), 0);
        chk({name, "_held_key"},   int'(v.stop ? key1 : key0), int'(v.exp_key));
    endtask

    vec_t vecs[$];
    vec_t tb_full, tb_stop;

    initial begin
        int  cycles, zpt, zct, hist[256];
        bit  ab;

        tb_full = model_search(1'b0, 8'h97, 8'h38);
        tb_stop = model_search(1'b1, 8'h97, 8'h38);
        chk("textbook_key_0x105_matches", model_enc(10'h105, 8'h97), 8'h38);

        // Pair with no matching key: histogram of ciphertexts over all keys
        zpt = -1; zct = -1;
        for (int p = 0; p < 256 && zct < 0; p++) begin
            for (int c = 0; c < 256; c++) hist[c] = 0;
            for (int k = 0; k < 1024; k++) hist[model_enc(k, p)]++;
            for (int c = 0; c < 256; c++) if (zct < 0 && hist[c] == 0) begin zpt = p; zct = c; end
        end
        chk("zero_match_pair_exists", int'(zct >= 0), 1);

        vecs.push_back(tb_full);
        vecs.push_back(tb_stop);
        if (zct >= 0) vecs.push_back(model_search(1'b0, zpt, zct));
        for (int i = 0; i < 3; i++) begin
            int pt, key;
            pt  = $urandom_range(0, 255);
            key = $urandom_range(0, 1023);
            vecs.push_back(model_search(1'b0, pt, model_enc(key, pt)));
            vecs.push_back(model_search(1'b1, pt, model_enc(key, pt)));
            vecs.push_back(model_search(1'b1, pt, $urandom_range(0, 255)));
        end

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_all_zero("reset");
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk_all_zero("after_release");

        for (int i = 0; i < vecs.size(); i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Start and data changes during a search are ignored
        launch(1'b0, 8'h97, 8'h38);
        wait_done(1'b0, 300, -1, cycles, ab);
        check_result("ignore_start", tb_full, cycles);

        // Reset mid-search, then a clean search
        launch(1'b0, 8'h97, 8'h38);
        wait_done(1'b0, -1, 500, cycles, ab);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        run_vec("after_reset", tb_full);

        // start held through DONE: second search begins with no idle cycle
        @(negedge CLOCK_50);
        plaintext = 8'h97; ciphertext = 8'h38; start0 = 1'b1;
        @(posedge CLOCK_50);
        #1;
        wait_done(1'b0, -1, -1, cycles, ab);
        check_result("b2b_first", tb_full, cycles);
        @(posedge CLOCK_50);
        #1;
        chk("b2b_busy",  int'(busy0), 1);
        chk("b2b_done",  int'(done0), 0);
        chk("b2b_clear_found", int'(found0), 0);
        chk("b2b_clear_key",   int'(key0), 0);
        chk("b2b_clear_count", int'(count0), 0);
        start0 = 1'b0;
        wait_done(1'b0, -1, -1, cycles, ab);
        check_result("b2b_second", tb_full, cycles);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
